// File: rtl/seg7_scan_engine.sv
// Multiplexed seven-segment display engine: sequential binary-to-BCD conversion
// or hex pass-through, saturation, decimal point and leading-zero blanking.
module seg7_scan_engine #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [DATA_W-1:0]                                  din,
    input  logic                                               din_valid,
    output logic                                               din_ready,
    input  logic                                               hex_mode,
    input  logic [$clog2((NUM_DIGITS < 2) ? 2 : NUM_DIGITS)-1:0] dec,
    input  logic                                               dp_en,
    input  logic                                               blank_lz,
    input  logic                                               enable,
    output logic [NUM_DIGITS-1:0]                              an,
    output logic [6:0]                                         seg,
    output logic                                               dp,
    output logic [4*NUM_DIGITS-1:0]                            digits,
    output logic                                               overflow
);

    localparam int unsigned IDX_W     = $clog2((NUM_DIGITS < 2) ? 2 : NUM_DIGITS);
    localparam int unsigned DIV       = ((CLK_HZ / REFRESH_HZ) < 1) ? 1 : (CLK_HZ / REFRESH_HZ);
    localparam int unsigned PRE_W     = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned BCD_N     = (DATA_W * 30103 + 99999) / 100000 + 1;
    localparam int unsigned BCD_W     = 4 * BCD_N;
    localparam int unsigned DIG_W     = 4 * NUM_DIGITS;
    localparam int unsigned HEX_EXT_W = (DATA_W > DIG_W) ? DATA_W : DIG_W;
    localparam int unsigned BCD_EXT_W = (BCD_W > DIG_W) ? BCD_W : DIG_W;
    localparam int unsigned CNT_W     = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 din_ready_q, din_ready_d;
    logic                 accept_c, load_c, step_c, commit_c;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 disp_hex_q, disp_hex_d;
    logic [DIG_W-1:0]     digits_q, digits_d, commit_val;
    logic                 overflow_q, overflow_d;
    logic [HEX_EXT_W-1:0] hex_ext;
    logic [BCD_EXT_W-1:0] bcd_ext;
    logic                 hex_ovf, dec_ovf, commit_ovf;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 tick_c;
    logic [3:0]           cur_nib;
    logic                 lz_acc, lz_cur, dp_act, blank_c;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    function automatic logic [6:0] font7(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign accept_c = din_valid & din_ready_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = hex_mode ? S_COMMIT : S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        load_c      = 1'b0;
        step_c      = 1'b0;
        commit_c    = 1'b0;
        din_ready_d = (state_d == S_IDLE);
        case (state_q)
            S_IDLE:    load_c   = accept_c;
            S_CONVERT: step_c   = 1'b1;
            S_COMMIT:  commit_c = 1'b1;
            default:   ;
        endcase
    end

    // Double-dabble: add 3 to digits >= 5, then shift in the next sample bit
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_N); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        if (load_c) begin
            shift_d = din;
            bcd_d   = '0;
            cnt_d   = '0;
            mode_d  = hex_mode;
        end else if (step_c) begin
            shift_d = shift_q << 1;
            bcd_d   = (bcd_adj << 1) | BCD_W'(shift_q[DATA_W-1]);
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Commit: saturate and load the visible digit register in one cycle
    always_comb begin
        hex_ext    = HEX_EXT_W'(shift_q);
        bcd_ext    = BCD_EXT_W'(bcd_q);
        hex_ovf    = |(hex_ext >> DIG_W);
        dec_ovf    = |(bcd_ext >> DIG_W);
        commit_ovf = mode_q ? hex_ovf : dec_ovf;
        commit_val = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (mode_q) begin
                commit_val[4*i +: 4] = hex_ovf ? 4'hF : hex_ext[4*i +: 4];
            end else begin
                commit_val[4*i +: 4] = dec_ovf ? 4'h9 : bcd_ext[4*i +: 4];
            end
        end
        digits_d   = digits_q;
        overflow_d = overflow_q;
        disp_hex_d = disp_hex_q;
        if (commit_c) begin
            digits_d   = commit_val;
            overflow_d = commit_ovf;
            disp_hex_d = mode_q;
        end
    end

    // Scan prescaler and digit index
    always_comb begin
        tick_c = (pre_q == PRE_W'(DIV - 1));
        pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
        idx_d  = idx_q;
        if (tick_c) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Display drive for the current index
    always_comb begin
        cur_nib = '0;
        lz_acc  = 1'b1;
        lz_cur  = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            lz_acc = lz_acc & (digits_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                cur_nib = digits_q[4*i +: 4];
                lz_cur  = lz_acc;
            end
        end
        dp_act  = dp_en & (32'(dec) < NUM_DIGITS);
        blank_c = !disp_hex_q && blank_lz && (idx_q != '0) && lz_cur
                  && (!dp_act || (idx_q > dec));
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            an_d[i] = !(enable && (idx_q == IDX_W'(i)));
        end
        seg_d = (!enable || blank_c) ? 7'h7F : font7(cur_nib);
        dp_d  = !(enable && dp_act && (idx_q == dec));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_ready_q <= 1'b1;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            disp_hex_q  <= 1'b0;
            digits_q    <= '0;
            overflow_q  <= 1'b0;
            pre_q       <= '0;
            idx_q       <= '0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            din_ready_q <= din_ready_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            disp_hex_q  <= disp_hex_d;
            digits_q    <= digits_d;
            overflow_q  <= overflow_d;
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign din_ready = din_ready_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digits    = digits_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg7_scan_engine.sv
// Self-checking bench for seg7_scan_engine: conversion table with a scoreboard,
// scan/glyph sequences, busy handshake, enable pulse and mid-run reset.
module tb_seg7_scan_engine;

    localparam int unsigned ND = 4;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          hex_mode;
    logic [1:0]    dec;
    logic          dp_en;
    logic          blank_lz;
    logic          enable;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic [4*ND-1:0] digits;
    logic          overflow;

    seg7_scan_engine #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .CLK_HZ     (1000),
        .REFRESH_HZ (250)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .hex_mode  (hex_mode),
        .dec       (dec),
        .dp_en     (dp_en),
        .blank_lz  (blank_lz),
        .enable    (enable),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digits    (digits),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic          hex;
        logic [DW-1:0] din;
        logic [15:0]   exp_dig;
        logic          exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] dig;
        logic        ovf;
        int          busy;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample, track the busy window and compare against the scoreboard
    task automatic run_vec(input string tag, input vec_t v);
        exp_t        e;
        int          n;
        logic        early;
        logic [15:0] prev;
        check({tag, "_ready_idle"}, 32'(din_ready), 32'(1'b1));
        prev      = digits;
        hex_mode  = v.hex;
        din       = v.din;
        din_valid = 1'b1;
        e.dig     = v.exp_dig;
        e.ovf     = v.exp_ovf;
        e.busy    = v.hex ? 1 : int'(DW) + 1;
        sb.push_back(e);
        step();
        din_valid = 1'b0;
        n     = 0;
        early = 1'b0;
        while (!din_ready && n < 100) begin
            if (digits !== prev) early = 1'b1;
            n++;
            step();
        end
        e = sb.pop_front();
        check({tag, "_busy_cycles"}, 32'(n), 32'(e.busy));
        check({tag, "_no_partial"}, 32'(early), 32'(1'b0));
        check({tag, "_digits"}, 32'(digits), 32'(e.dig));
        check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
    endtask

    // Wait for the first cycle of the digit-0 slot; returns cycle stamp
    task automatic sync_slot0(input string tag, output int t);
        int n;
        n = 0;
        while (an === 4'b1110 && n < 50) begin n++; step(); end
        while (an !== 4'b1110 && n < 50) begin n++; step(); end
        check({tag, "_sync"}, 32'(n < 50), 32'(1'b1));
        t = cyc;
    endtask

    // Walk the four slots; es packs digit i glyph at [7*i +: 7]
    task automatic scan_check(input string tag, input logic [27:0] es, input logic [3:0] edp);
        int         t;
        logic [3:0] ea;
        sync_slot0(tag, t);
        for (int i = 0; i < 4; i++) begin
            ea    = 4'b1111;
            ea[i] = 1'b0;
            check($sformatf("%s_an%0d", tag, i), 32'(an), 32'(ea));
            check($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(es[7*i +: 7]));
            check($sformatf("%s_dp%0d", tag, i), 32'(dp), 32'(edp[i]));
            repeat (4) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   t0, t1, n, acc_cnt;

        vecs[0]  = '{1'b0, 16'd1234,  16'h1234, 1'b0};
        vecs[1]  = '{1'b0, 16'd12345, 16'h9999, 1'b1};
        vecs[2]  = '{1'b0, 16'd0,     16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 16'hBEEF,  16'hBEEF, 1'b0};
        vecs[4]  = '{1'b0, 16'd9999,  16'h9999, 1'b0};
        vecs[5]  = '{1'b0, 16'd10000, 16'h9999, 1'b1};
        vecs[6]  = '{1'b0, 16'd65535, 16'h9999, 1'b1};
        vecs[7]  = '{1'b1, 16'h0000,  16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 16'd7,     16'h0007, 1'b0};
        vecs[9]  = '{1'b0, 16'd4095,  16'h4095, 1'b0};
        vecs[10] = '{1'b1, 16'h1234,  16'h1234, 1'b0};
        vecs[11] = '{1'b0, 16'd5050,  16'h5050, 1'b0};

        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        hex_mode  = 1'b0;
        dec       = 2'd0;
        dp_en     = 1'b0;
        blank_lz  = 1'b0;
        enable    = 1'b1;
        #23;
        check("rst_an", 32'(an), 32'(4'b1111));
        check("rst_seg", 32'(seg), 32'(7'h7F));
        check("rst_dp", 32'(dp), 32'(1'b1));
        check("rst_digits", 32'(digits), 32'(16'h0000));
        check("rst_overflow", 32'(overflow), 32'(1'b0));
        check("rst_ready", 32'(din_ready), 32'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Decimal 1234 scanned right to left
        v = '{1'b0, 16'd1234, 16'h1234, 1'b0};
        run_vec("scan_dec", v);
        scan_check("scan_dec", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111);

        // Hex glyphs; blanking does not apply in hex mode
        blank_lz = 1'b1;
        v = '{1'b1, 16'hBEEF, 16'hBEEF, 1'b0};
        run_vec("scan_hex", v);
        scan_check("scan_hex", {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}, 4'b1111);
        v = '{1'b1, 16'h0000, 16'h0000, 1'b0};
        run_vec("hex_zero", v);
        scan_check("hex_zero", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111);

        // Leading-zero blanking held back by the decimal point
        dp_en = 1'b1;
        dec   = 2'd2;
        v = '{1'b0, 16'd7, 16'h0007, 1'b0};
        run_vec("lz_dp", v);
        scan_check("lz_dp", {7'h7F, 7'b1000000, 7'b1000000, 7'b1111000}, 4'b1011);
        dp_en = 1'b0;
        step();
        scan_check("lz_nodp", {7'h7F, 7'h7F, 7'h7F, 7'b1111000}, 4'b1111);

        // Valid held through busy, sample changed mid-conversion, enable pulse
        blank_lz = 1'b0;
        sync_slot0("cont_a", t0);
        acc_cnt   = 0;
        hex_mode  = 1'b0;
        din       = 16'd1234;
        din_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (din_valid && din_ready) acc_cnt++;
            if (k == 1) din = 16'd5555;
            if (k == 3) enable = 1'b0;
            if (k == 8) begin
                check("dark_an", 32'(an), 32'(4'b1111));
                check("dark_seg", 32'(seg), 32'(7'h7F));
                check("dark_dp", 32'(dp), 32'(1'b1));
                enable = 1'b1;
            end
            step();
        end
        din_valid = 1'b0;
        n = 0;
        while (!din_ready && n < 100) begin n++; step(); end
        check("hold_ready_back", 32'(n < 100), 32'(1'b1));
        check("hold_accepts", 32'(acc_cnt), 32'(1));
        check("hold_digits", 32'(digits), 32'(16'h1234));
        sync_slot0("cont_b", t1);
        check("index_continuity", 32'((t1 - t0) % 16), 32'(0));

        // Reset in the middle of a conversion discards it
        din       = 16'd4321;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'(4'b1111));
        check("midrst_seg", 32'(seg), 32'(7'h7F));
        check("midrst_dp", 32'(dp), 32'(1'b1));
        check("midrst_digits", 32'(digits), 32'(16'h0000));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("midrst_ready", 32'(din_ready), 32'(1'b1));
        repeat (20) step();
        check("midrst_discard", 32'(digits), 32'(16'h0000));
        v = '{1'b0, 16'd42, 16'h0042, 1'b0};
        run_vec("after_rst", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
